// File: rtl/cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// cpu_trace_buffer
//
// Retirement-trace capture block for the MIPS-lite CPU. Each qualified
// retirement (pc, instr, alu_result, reg_write_en) is written into a DEPTH-entry
// first-word-fall-through FIFO and drained through a valid/ready port. Also
// provides a filter mode, a PC-match trigger that freezes capture POST_TRIG
// entries after the hit, and a saturating count of dropped entries.
//
// Optional feature: define TRACE_TIMESTAMP_EN to store a free-running 32-bit
// cycle count with every entry. The count comes out on the extra port tr_ts.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-low reset
//   enable        arm/run capture
//   clear         synchronous flush of the FIFO and statistics
//   mode          0 = capture all retirements, 1 = only reg_write_en=1
//   trig_en       enable the PC-match trigger
//   trig_pc       PC that fires the trigger
//   cap_valid     retirement strobe qualifying pc/instr/alu_result/reg_write_en
//   pc, instr, alu_result, reg_write_en   retiring instruction fields
//   tr_valid      head entry available
//   tr_ready      consumer accepts the head entry
//   tr_pc, tr_instr, tr_alu, tr_we, tr_trig   head entry fields (0 when empty)
//   count         FIFO occupancy
//   overflow      sticky, at least one entry was dropped
//   drop_cnt      dropped entries, saturating at all-ones
//   frozen        capture frozen after the trigger window
//   tr_ts         (TRACE_TIMESTAMP_EN only) cycle count at the capture edge
// -----------------------------------------------------------------------------
module cpu_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     cap_valid,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        instr,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     reg_write_en,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [DATA_W-1:0]        tr_pc,
  output logic [DATA_W-1:0]        tr_instr,
  output logic [DATA_W-1:0]        tr_alu,
  output logic                     tr_we,
  output logic                     tr_trig,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     frozen
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]              tr_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } state_t;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       ts;
`endif
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] alu;
    logic              we;
    logic              trig;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wrEntry;
  entry_t          rdEntry;

  state_t          state_q, state_d;
  logic [CW-1:0]   postCnt_q, postCnt_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]     tsCnt_q, tsCnt_d;
`endif

  logic qual, pushReq, trigHit, popEn, full, pushEn, dropEn;

  // Request qualification and FIFO handshake decisions. A full FIFO still
  // accepts a push when the head leaves in the same cycle; otherwise the
  // request is dropped and accounted for.
  always_comb begin
    qual    = cap_valid & (~mode | reg_write_en);
    pushReq = qual & ((state_q == RUN) | (state_q == POST));
    trigHit = pushReq & (state_q == RUN) & trig_en & (pc == trig_pc);
    popEn   = tr_valid & tr_ready;
    full    = (count_q == CW'(DEPTH));
    pushEn  = pushReq & (~full | popEn);
    dropEn  = pushReq & full & ~popEn;
  end

  // Capture FSM. A dropped request still advances the post-trigger window,
  // so the freeze point depends only on retirements, not on FIFO space.
  always_comb begin
    state_d   = state_q;
    postCnt_d = postCnt_q;
    if (clear) begin
      state_d   = enable ? RUN : IDLE;
      postCnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (trigHit) begin
            postCnt_d = '0;
            state_d   = (POST_TRIG == 0) ? FROZEN : POST;
          end
        end
        POST: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (pushReq) begin
            postCnt_d = postCnt_q + CW'(1);
            if (postCnt_q + CW'(1) == CW'(POST_TRIG)) state_d = FROZEN;
          end
        end
        FROZEN: begin
          state_d = FROZEN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and drop statistics. Clear wins over any
  // push or pop in the same cycle.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    if (clear) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      dropCnt_d  = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + AW'(1);
      if (popEn)  rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + CW'(pushEn) - CW'(popEn);
      if (dropEn) begin
        overflow_d = 1'b1;
        if (dropCnt_q != '1) dropCnt_d = dropCnt_q + CNT_W'(1);
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_comb begin
    tsCnt_d = clear ? 32'd0 : tsCnt_q + 32'd1;
  end
`endif

  always_comb begin
    wrEntry       = '0;
`ifdef TRACE_TIMESTAMP_EN
    wrEntry.ts    = tsCnt_q;
`endif
    wrEntry.pc    = pc;
    wrEntry.instr = instr;
    wrEntry.alu   = alu_result;
    wrEntry.we    = reg_write_en;
    wrEntry.trig  = trigHit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      postCnt_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
`ifdef TRACE_TIMESTAMP_EN
      tsCnt_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      postCnt_q  <= postCnt_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
`ifdef TRACE_TIMESTAMP_EN
      tsCnt_q    <= tsCnt_d;
`endif
    end
  end

  // Storage is not reset; stale contents are masked by tr_valid below.
  always_ff @(posedge clk) begin
    if (pushEn && !clear) mem[wrPtr_q] <= wrEntry;
  end

  always_comb begin
    rdEntry  = mem[rdPtr_q];
    tr_valid = (count_q != '0);
    tr_pc    = tr_valid ? rdEntry.pc    : '0;
    tr_instr = tr_valid ? rdEntry.instr : '0;
    tr_alu   = tr_valid ? rdEntry.alu   : '0;
    tr_we    = tr_valid & rdEntry.we;
    tr_trig  = tr_valid & rdEntry.trig;
`ifdef TRACE_TIMESTAMP_EN
    tr_ts    = tr_valid ? rdEntry.ts : '0;
`endif
    count    = count_q;
    overflow = overflow_q;
    drop_cnt = dropCnt_q;
    frozen   = (state_q == FROZEN);
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_buffer
//
// Self-checking bench for cpu_trace_buffer (default parameters). Captured
// entries expected by the bench are pushed into a scoreboard queue when the
// retirement is driven and popped/compared as the DUT hands them out.
// -----------------------------------------------------------------------------
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, clear, mode, trig_en;
  logic [31:0] trig_pc;
  logic        cap_valid;
  logic [31:0] pc, instr, alu_result;
  logic        reg_write_en;
  logic        tr_valid, tr_ready;
  logic [31:0] tr_pc, tr_instr, tr_alu;
  logic        tr_we, tr_trig;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        frozen;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] tr_ts;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic        we;
    logic        trig;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    logic        mode;
    logic [31:0] pc;
    logic        we;
    logic        expCap;
    int          expCount;
    logic        drainAfter;
  } vec_t;

  vec_t vecs[7];

  cpu_trace_buffer #(
    .DATA_W(32), .DEPTH(16), .POST_TRIG(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .cap_valid(cap_valid), .pc(pc),
    .instr(instr), .alu_result(alu_result), .reg_write_en(reg_write_en),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .tr_alu(tr_alu), .tr_we(tr_we), .tr_trig(tr_trig),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .frozen(frozen)
`ifdef TRACE_TIMESTAMP_EN
    , .tr_ts(tr_ts)
`endif
  );

  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instrOf(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] aluOf(input logic [31:0] p);
    return p + 32'h0000_1000;
  endfunction

  // Drive one retirement; the caller advances the clock.
  task automatic applyStimulus(input logic [31:0] p, input logic we);
    cap_valid    = 1'b1;
    pc           = p;
    instr        = instrOf(p);
    alu_result   = aluOf(p);
    reg_write_en = we;
  endtask

  task automatic idleInputs();
    cap_valid    = 1'b0;
    reg_write_en = 1'b0;
  endtask

  task automatic expectEntry(input logic [31:0] p, input logic we, input logic trig);
    sb_t e;
    e.pc = p; e.instr = instrOf(p); e.alu = aluOf(p); e.we = we; e.trig = trig;
    sb.push_back(e);
  endtask

  // Compare the current head against the scoreboard front and consume it.
  task automatic checkHead();
    sb_t e;
    e = sb.pop_front();
    checkOutput("head_pc", tr_pc, e.pc);
    checkOutput("head_fields", {tr_instr, tr_alu, tr_we, tr_trig},
                {e.instr, e.alu, e.we, e.trig});
  endtask

  task automatic drain();
    tr_ready = 1'b1;
    for (int i = 0; i < 64 && sb.size() > 0; i++) begin
      if (tr_valid) checkHead();
      tick();
    end
    tr_ready = 1'b0;
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
    checkOutput("drain_valid", tr_valid, 1'b0);
    checkOutput("drain_count", count, 5'd0);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mode: 1'b0, pc: 32'h0,   we: 1'b1, expCap: 1'b1, expCount: 1, drainAfter: 1'b0};
    vecs[1] = '{mode: 1'b0, pc: 32'h4,   we: 1'b0, expCap: 1'b1, expCount: 2, drainAfter: 1'b0};
    vecs[2] = '{mode: 1'b0, pc: 32'h8,   we: 1'b1, expCap: 1'b1, expCount: 3, drainAfter: 1'b1};
    vecs[3] = '{mode: 1'b1, pc: 32'h100, we: 1'b1, expCap: 1'b1, expCount: 1, drainAfter: 1'b0};
    vecs[4] = '{mode: 1'b1, pc: 32'h104, we: 1'b0, expCap: 1'b0, expCount: 1, drainAfter: 1'b0};
    vecs[5] = '{mode: 1'b1, pc: 32'h108, we: 1'b1, expCap: 1'b1, expCount: 2, drainAfter: 1'b0};
    vecs[6] = '{mode: 1'b1, pc: 32'h10C, we: 1'b0, expCap: 1'b0, expCount: 2, drainAfter: 1'b1};

    reset = 1'b0; enable = 1'b0; clear = 1'b0; mode = 1'b0; trig_en = 1'b0;
    trig_pc = 32'h0; tr_ready = 1'b0; pc = '0; instr = '0; alu_result = '0;
    idleInputs();
    #1;
    checkOutput("reset_valid", tr_valid, 1'b0);
    checkOutput("reset_count", count, 5'd0);
    checkOutput("reset_flags", {overflow, frozen, drop_cnt}, 10'd0);
    checkOutput("reset_pc", tr_pc, 32'd0);
    tick(); tick();
    reset = 1'b1;
    enable = 1'b1;
    tick();

    // Basic FIFO and filter mode from the vector table.
    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].mode;
      applyStimulus(vecs[v].pc, vecs[v].we);
      if (vecs[v].expCap) expectEntry(vecs[v].pc, vecs[v].we, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_count", v), count, 5'(vecs[v].expCount));
      if (vecs[v].drainAfter) begin
        idleInputs();
        drain();
      end
    end
    mode = 1'b0;

    // Overflow: 20 retirements into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'h200 + 32'(4 * i), 1'b1);
      if (i < 16) expectEntry(32'h200 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    idleInputs();
    checkOutput("ovf_count", count, 5'd16);
    checkOutput("ovf_flag", overflow, 1'b1);
    checkOutput("ovf_drop", drop_cnt, 8'd4);
    // Push with simultaneous pop while full.
    tr_ready = 1'b1;
    applyStimulus(32'h300, 1'b1);
    checkHead();
    expectEntry(32'h300, 1'b1, 1'b0);
    tick();
    idleInputs();
    tr_ready = 1'b0;
    checkOutput("fullpop_count", count, 5'd16);
    checkOutput("fullpop_drop", drop_cnt, 8'd4);
    drain();
    checkOutput("ovf_sticky", overflow, 1'b1);
    pulseClear();
    checkOutput("clear_stats", {overflow, drop_cnt}, 9'd0);

    // Trigger at 0x40 with a four-entry post window.
    trig_en = 1'b1;
    trig_pc = 32'h40;
    for (int i = 0; i < 17; i++) begin
      logic [31:0] p;
      p = 32'h30 + 32'(4 * i);
      applyStimulus(p, 1'b0);
      if (p <= 32'h50) expectEntry(p, 1'b0, p == 32'h40);
      tick();
      if (p == 32'h4C) checkOutput("trig_not_frozen", frozen, 1'b0);
      if (p == 32'h50) checkOutput("trig_frozen", frozen, 1'b1);
    end
    idleInputs();
    trig_en = 1'b0;
    checkOutput("trig_count", count, 5'd9);
    checkOutput("trig_drop", drop_cnt, 8'd0);
    drain();
    checkOutput("frozen_after_drain", frozen, 1'b1);
    applyStimulus(32'h80, 1'b1);
    tick();
    idleInputs();
    checkOutput("frozen_ignores", count, 5'd0);
    pulseClear();
    checkOutput("clear_unfreeze", frozen, 1'b0);

    // Clear flushes buffered contents.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h500 + 32'(4 * i), 1'b1);
      tick();
    end
    idleInputs();
    checkOutput("preclear_count", count, 5'd3);
    pulseClear();
    checkOutput("clear_count", count, 5'd0);
    checkOutput("clear_valid", tr_valid, 1'b0);

    // Reset asserted between edges with five entries buffered.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h600 + 32'(4 * i), 1'b1);
      tick();
    end
    idleInputs();
    checkOutput("prereset_count", count, 5'd5);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_valid", tr_valid, 1'b0);
    checkOutput("async_count", count, 5'd0);
    checkOutput("async_flags", {overflow, frozen}, 2'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("postreset_count", count, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
